aes_sbox_fwd_iter: RTL

- Multi-cycle forward AES S-box engine: S(x) = Affine(x^254 in GF(2^8)), reduction polynomial x^8+x^4+x^3+x+1.
- Counterpart to the inverse-S-box datapath (inverse affine map followed by field inversion). It supplies the encrypt-direction substitution for the key schedule and the area-optimised round.
- Field inversion is computed iteratively by square-and-multiply on one shared GF(2^8) multiplier. Valid/ready handshake on both sides.

---
 rtl/aes_gf_pkg.sv | 44 ++++
 rtl/gf256_mul.sv | 24 ++
 rtl/aes_sbox_fwd_iter.sv | 105 ++++++++++
 3 files changed

// File: rtl/aes_gf_pkg.sv
// Shared GF(2^8) helpers, constants and FSM encoding for the AES S-box engines.
package aes_gf_pkg;

    localparam logic [7:0] AES_POLY     = 8'h1B;  // x^8 + x^4 + x^3 + x + 1, low byte
    localparam logic [7:0] AES_AFFINE_C = 8'h63;  // forward affine constant
    localparam logic [2:0] CNT_LAST     = 3'd5;   // last square-and-multiply step

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Fold a 15-bit carry-less product back into the field.
    function automatic logic [7:0] gf_reduce(input logic [14:0] p, input logic [7:0] poly);
        logic [14:0] r;
        logic [14:0] m;
        r = p;
        m = {6'd0, 1'b1, poly};
        for (int k = 14; k >= 8; k--) begin
            if (((r >> k) & 15'd1) != 15'd0) r = r ^ (m << (k - 8));
        end
        return r[7:0];
    endfunction

    // Squaring is linear in GF(2): spread bits to even positions, then reduce.
    function automatic logic [7:0] gf_sq(input logic [7:0] x, input logic [7:0] poly);
        logic [14:0] p;
        p = {x[7], 1'b0, x[6], 1'b0, x[5], 1'b0, x[4], 1'b0,
             x[3], 1'b0, x[2], 1'b0, x[1], 1'b0, x[0]};
        return gf_reduce(p, poly);
    endfunction

    // b_i = x_i ^ x_(i+4) ^ x_(i+5) ^ x_(i+6) ^ x_(i+7) ^ c_i, written as right rotations.
    function automatic logic [7:0] fwd_affine(input logic [7:0] x, input logic [7:0] c);
        return x
             ^ {x[3:0], x[7:4]}
             ^ {x[4:0], x[7:5]}
             ^ {x[5:0], x[7:6]}
             ^ {x[6:0], x[7]}
             ^ c;
    endfunction

endpackage

// File: rtl/gf256_mul.sv
// Combinational GF(2^8) multiplier: carry-less 8x8 product folded by the reduction polynomial.
module gf256_mul #(
    parameter logic [7:0] POLY = 8'h1B
) (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    output logic [7:0] p_o
);

    logic [14:0] full;

    // Shift-and-xor partial products, then clear bits 14..8 from the top down.
    always_comb begin
        full = '0;
        for (int j = 0; j < 8; j++) begin
            if (((b_i >> j) & 8'd1) != 8'd0) full = full ^ ({7'd0, a_i} << j);
        end
        for (int k = 14; k >= 8; k--) begin
            if (((full >> k) & 15'd1) != 15'd0) full = full ^ ({6'd0, 1'b1, POLY} << (k - 8));
        end
        p_o = full[7:0];
    end

endmodule

// File: rtl/aes_sbox_fwd_iter.sv
// Multi-cycle forward AES S-box: x^254 by square-and-multiply on one shared
// multiplier, then the forward affine map. Valid/ready on both sides.
module aes_sbox_fwd_iter
    import aes_gf_pkg::*;
#(
    parameter logic [7:0] POLY     = AES_POLY,
    parameter logic [7:0] AFFINE_C = AES_AFFINE_C
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] data_in,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] data_out,
    output logic       busy
);

    state_e     state_q, state_d;
    logic [7:0] sq_q, sq_d;
    logic [7:0] acc_q, acc_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] data_out_q, data_out_d;
    logic       out_valid_q, out_valid_d;

    logic [7:0] sq_sq;
    logic [7:0] prod;

    // sq walks x^4, x^8, ... x^128; acc collects the running product of those powers.
    assign sq_sq = gf_sq(sq_q, POLY);

    gf256_mul #(.POLY(POLY)) u_mul (
        .a_i (acc_q),
        .b_i (sq_sq),
        .p_o (prod)
    );

    // Next-state and datapath updates for the three-state engine.
    always_comb begin
        state_d     = state_q;
        sq_d        = sq_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        data_out_d  = data_out_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sq_d    = gf_sq(data_in, POLY);
                    acc_d   = gf_sq(data_in, POLY);
                    cnt_d   = 3'd0;
                    state_d = CALC;
                end
            end
            CALC: begin
                sq_d  = sq_sq;
                acc_d = prod;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == CNT_LAST) begin
                    // prod is x^254 here; zero input falls out as 0 with no special case.
                    data_out_d  = fwd_affine(prod, AFFINE_C);
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sq_q        <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sq_q        <= sq_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    // in_ready is masked by reset so every output reads 0 while reset is held.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign data_out  = data_out_q;

endmodule
